// File: rtl/dmem_responder.sv
// Single-port data memory responder for a load/store unit: one outstanding request,
// fixed wait-state latency, byte-lane writes and out-of-range error reporting.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic        resp_ready
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready=1
    // WAIT  | request captured, counting down wait states
    // RESP  | response presented until resp_ready
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int AW        = $clog2(DEPTH_WORDS);
    localparam int WAIT_INIT = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        wr_q;
    logic [29:0] idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic          cur_wr;
    logic [29:0]   cur_idx;
    logic [31:0]   cur_wdata;
    logic [3:0]    cur_wmask;
    logic          cur_oor;
    logic [AW-1:0] mem_addr;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^req_addr[1:0];

    assign accept     = (state == IDLE) && req_valid;
    assign enter_resp = (state_nx == RESP) && (state != RESP);

    // With zero wait states RESP is entered on the accept edge itself, so the
    // live request fields must be used instead of the captured copies.
    assign cur_wr    = (state == IDLE) ? req_wr          : wr_q;
    assign cur_idx   = (state == IDLE) ? req_addr[31:2]  : idx_q;
    assign cur_wdata = (state == IDLE) ? req_wdata       : wdata_q;
    assign cur_wmask = (state == IDLE) ? req_wmask       : wmask_q;
    assign cur_oor   = cur_idx >= 30'(DEPTH_WORDS);
    assign mem_addr  = cur_idx[AW-1:0];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = 4'(WAIT_INIT);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nx = RESP;
                else             cnt_nx   = cnt - 4'd1;
            end
            RESP: begin
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                wr_q    <= req_wr;
                idx_q   <= req_addr[31:2];
                wdata_q <= req_wdata;
                wmask_q <= req_wmask;
            end
            if (enter_resp) begin
                err_q   <= cur_oor;
                rdata_q <= (cur_wr || cur_oor) ? 32'd0 : mem[mem_addr];
            end
        end
    end

    // Array has no reset so its contents survive; commits are blocked while reset is high.
    always_ff @(posedge clk) begin
        if (enter_resp && !reset && cur_wr && !cur_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_wmask[b]) mem[mem_addr][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state and one
// with zero wait states, checked against hand-computed values.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        req_valid = 0, req_wr = 0, resp_ready = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0]  req_wmask = 0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        req_valid0 = 0, req_wr0 = 0, resp_ready0 = 0;
    logic [31:0] req_addr0 = 0, req_wdata0 = 0;
    logic [3:0]  req_wmask0 = 0;
    logic        req_ready0, resp_valid0, resp_err0;
    logic [31:0] resp_rdata0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .resp_ready(resp_ready)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_wr(req_wr0), .req_addr(req_addr0),
        .req_wdata(req_wdata0), .req_wmask(req_wmask0), .req_ready(req_ready0),
        .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
        .resp_ready(resp_ready0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One transaction on u_dut; request fields are scrambled after accept to
    // prove the captured copies are what gets used.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, output logic [31:0] rd, output logic er,
                       output int lat);
        int n;
        rd  = '0;
        er  = 1'b0;
        lat = 0;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = mask;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wr    = ~wr;
        req_addr  = 32'hFFFF_FFF0;
        req_wdata = ~wdata;
        req_wmask = ~mask;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) begin
            check("resp_timeout", 32'd0, 32'd1);
            return;
        end
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn(wr, addr, wdata, mask, rd, er, lat);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, 32'(er), 32'(exp_er));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_resp_valid0", 32'(resp_valid0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_req_ready0", 32'(req_ready0), 32'd1);

        // basic write then read, two-cycle latency
        xfer("wr10", 1, 32'h10, 32'hAABB_CCDD, 4'hF, 32'd0, 0);
        xfer("rd10", 0, 32'h10, 32'd0, 4'h0, 32'hAABB_CCDD, 0);

        // lane merge
        xfer("wr10b", 1, 32'h10, 32'h1122_3344, 4'hF, 32'd0, 0);
        xfer("wr10m", 1, 32'h10, 32'h00EE_0000, 4'h4, 32'd0, 0);
        xfer("rd10m", 0, 32'h10, 32'd0, 4'h0, 32'h11EE_3344, 0);
        xfer("wr10z", 1, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'd0, 0);
        xfer("rd10z", 0, 32'h10, 32'd0, 4'h0, 32'h11EE_3344, 0);
        xfer("rd13", 0, 32'h13, 32'd0, 4'h0, 32'h11EE_3344, 0);

        // range boundaries
        xfer("wr0", 1, 32'h0, 32'hCAFE_F00D, 4'hF, 32'd0, 0);
        xfer("wr400", 1, 32'h400, 32'hDEAD_BEEF, 4'hF, 32'd0, 1);
        xfer("rd0", 0, 32'h0, 32'd0, 4'h0, 32'hCAFE_F00D, 0);
        xfer("wr3fc", 1, 32'h3FC, 32'h5A5A_5A5A, 4'hF, 32'd0, 0);
        xfer("rdhi", 0, 32'hFFFF_FFFC, 32'd0, 4'h0, 32'd0, 1);
        xfer("rd3fc", 0, 32'h3FC, 32'd0, 4'h0, 32'h5A5A_5A5A, 0);

        // backpressure: hold resp_ready low for 5 cycles with a competing request
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 32'h3FC;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int h = 0; h < 5; h++) begin
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, 32'h5A5A_5A5A);
            check("hold_ready", 32'(req_ready), 32'd0);
            req_valid = 1'b1;
            req_wr    = 1'b1;
            req_addr  = 32'h10;
            req_wdata = 32'd0;
            req_wmask = 4'hF;
            @(negedge clk);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("release_valid", 32'(resp_valid), 32'd0);
        check("release_ready", 32'(req_ready), 32'd1);
        xfer("rd10h", 0, 32'h10, 32'd0, 4'h0, 32'h11EE_3344, 0);

        // reset during WAIT abandons the write
        xfer("wr20", 1, 32'h20, 32'h1234_5678, 4'hF, 32'd0, 0);
        xfer("rd20", 0, 32'h20, 32'd0, 4'h0, 32'h1234_5678, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hFFFF_FFFF;
        req_wmask = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        check("abort_valid", 32'(resp_valid), 32'd0);
        check("abort_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_err", 32'(resp_err), 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(resp_valid), 32'd0);
        end
        xfer("rd20r", 0, 32'h20, 32'd0, 4'h0, 32'h1234_5678, 0);

        // zero wait states, back-to-back with resp_ready held high
        resp_ready0 = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (i % 2 == 0) begin
                    check("b2b_ready", 32'(req_ready0), 32'd1);
                    check("b2b_idle_valid", 32'(resp_valid0), 32'd0);
                    req_valid0 = 1'b1;
                    req_wr0    = (pass == 0);
                    req_addr0  = 32'((i / 2) * 4);
                    req_wdata0 = 32'hA000_0000 + 32'(i / 2);
                    req_wmask0 = 4'hF;
                end else begin
                    check("b2b_busy", 32'(req_ready0), 32'd0);
                    check("b2b_valid", 32'(resp_valid0), 32'd1);
                    check("b2b_rdata", resp_rdata0,
                          (pass == 1) ? 32'hA000_0000 + 32'(i / 2) : 32'd0);
                    check("b2b_err", 32'(resp_err0), 32'd0);
                    if (i == 7) req_valid0 = 1'b0;
                end
            end
        end
        @(negedge clk);
        check("b2b_end_valid", 32'(resp_valid0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words in the internal data array, power of two, minimum 4.
REQ-002 Parameter WAIT_STATES, default 1: extra cycles between request accept and response, range 0..15.
REQ-003 clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  the load/store unit presents a request.
REQ-006 req_wr  input  1  1 = write (store), 0 = read (load).
REQ-007 req_addr  input  32  byte address; bits [1:0] ignored; word index is req_addr[31:2].
REQ-008 req_wdata  input  32  lane-positioned store data.
REQ-009 req_wmask  input  4  byte-lane write enables; bit n enables bits [8n+7:8n].
REQ-010 req_ready  output  1  the responder accepts a request this cycle.
REQ-011 resp_valid  output  1  a response is presented.
REQ-012 resp_rdata  output  32  full read word; 0 for writes and for errors.
REQ-013 resp_err  output  1  the accepted address was out of range.
REQ-014 resp_ready  input  1  the consumer takes the response this cycle.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE, as a combinational decode of state.
REQ-017 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1, capturing req_wr, word index, req_wdata and req_wmask.
REQ-018 On accept, the FSM SHALL go to WAIT with wait counter = WAIT_STATES-1 when WAIT_STATES>0, or directly to RESP when WAIT_STATES=0.
REQ-019 In WAIT, the counter SHALL decrement each cycle; when it is 0, the FSM SHALL go to RESP on the next edge.
REQ-020 Request-accept-to-resp_valid latency SHALL be exactly WAIT_STATES+1 cycles.
REQ-021 In RESP, resp_valid SHALL be 1, and resp_rdata and resp_err SHALL stay stable until the cycle in which resp_ready=1.
REQ-022 On the edge where resp_valid=1 and resp_ready=1, the FSM SHALL return to IDLE; a new request cannot be accepted before the following cycle.
REQ-023 Out of range SHALL mean word index >= DEPTH_WORDS; such a request SHALL set resp_err=1 and resp_rdata=0, and SHALL NOT modify the array.
REQ-024 An in-range write SHALL update only the enabled lanes, exactly once, on the edge of entry into RESP.
REQ-025 A write with req_wmask=0 SHALL leave the array unchanged and SHALL still produce a response with resp_err=0.
REQ-026 An in-range read SHALL sample the array on the edge of entry into RESP, and that value SHALL be held in RESP.
REQ-027 A read that follows a write to the same word SHALL return the merged, post-write data.
REQ-028 Inputs SHALL be ignored outside IDLE; req_valid deasserting after accept SHALL have no effect.
REQ-029 resp_valid SHALL never assert without a prior accepted request; exactly one response SHALL be produced per accept.

Reset
REQ-030 While reset=1, the FSM SHALL be in IDLE, with the wait counter 0, resp_valid=0, resp_rdata=0 and resp_err=0; req_ready SHALL then be 1 once reset deasserts.
REQ-031 Reset asserted in WAIT or RESP SHALL abandon the transaction with no response.
REQ-032 A write SHALL commit only if reset is low at the RESP-entry edge.
REQ-033 The data array SHALL NOT be cleared by reset; its contents SHALL be preserved across reset.

Verification
REQ-034 WAIT_STATES=1: write addr 0x10, wdata 0xAABBCCDD, mask 0xF, then read 0x10 -> each resp_valid arrives 2 cycles after accept; the read returns 0xAABBCCDD with resp_err=0.
REQ-035 Write 0x11223344, mask 0xF; then write addr 0x10, wdata 0x00EE0000, mask 0x4; then read -> 0x11EE3344.
REQ-036 DEPTH_WORDS=256: write to addr 0x400 -> resp_err=1, rdata=0; a read of word 0 is unchanged; read of 0x3FC -> resp_err=0.
REQ-037 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and rdata stable, req_ready=0, and a new req_valid is ignored; resp_ready=1 -> IDLE the next cycle.
REQ-038 Assert reset one cycle after accepting a write of 0xFFFFFFFF to a word holding 0x12345678 -> no response; after reset, a read returns 0x12345678.
REQ-039 WAIT_STATES=0, back-to-back requests with resp_ready held at 1 -> one accept every 2 cycles, and each response arrives 1 cycle after its accept.
